// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of the single CPU-side cache port between r0 and r1.
// Define ARB_TIMEOUT_EN to add a watchdog that ends a stalled WAIT with an error ack.
module cache_port_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [2:0]        r0_cmd,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ack,
    output logic              r0_err,
    input  logic [2:0]        r1_cmd,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [2:0]        m_cmd,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_resp
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_err;
    logic [2:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_pend0;
    logic              w_pend1;
    logic              w_pick;
    logic              w_timeout;

    assign w_pend0 = (r0_cmd != 3'd0) && (r0_cmd != 3'd7);
    assign w_pend1 = (r1_cmd != 3'd0) && (r1_cmd != 3'd7);
    // On contention the requester that did not win last time goes next.
    assign w_pick  = (w_pend0 && w_pend1) ? ~r_last_grant : w_pend1;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // Fires in the WAIT cycle where the count reaches the limit; m_resp in that cycle still wins.
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= w_cnt_inc;
        end
    end
`else
    // The limit only matters when the watchdog is built in.
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYC);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_err        <= 1'b0;
            r_cmd        <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_pend0 || w_pend1) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_cmd        <= w_pick ? r1_cmd   : r0_cmd;
                        r_addr       <= w_pick ? r1_addr  : r0_addr;
                        r_wdata      <= w_pick ? r1_wdata : r0_wdata;
                    end
                end
                WAIT: begin
                    // A timed-out transaction returns zero data with the error flag.
                    if (m_resp || w_timeout) begin
                        r_err <= ~m_resp;
                        if (r_grant) begin
                            r_rdata1 <= m_resp ? m_rdata : '0;
                        end else begin
                            r_rdata0 <= m_resp ? m_rdata : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_cmd       = 3'd0;
        r0_ack      = 1'b0;
        r1_ack      = 1'b0;
        r0_err      = 1'b0;
        r1_err      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend0 || w_pend1) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                m_cmd       = r_cmd;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (m_resp || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                r0_ack      = ~r_grant;
                r1_ack      = r_grant;
                r0_err      = ~r_grant & r_err;
                r1_err      = r_grant & r_err;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign r0_rdata = r_rdata0;
    assign r1_rdata = r_rdata1;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a scoreboard queue holds each expected transaction,
// and a small cache model answers the issued command. ARB_TIMEOUT_EN adds the watchdog cases.
module tb_cache_port_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int TB_TO = 8;

    typedef struct packed {
        logic          who;
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
    } txn_t;

    logic          clk;
    logic          RESET;
    logic [2:0]    r0_cmd;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic [DW-1:0] r0_rdata;
    logic          r0_ack;
    logic          r0_err;
    logic [2:0]    r1_cmd;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic [DW-1:0] r1_rdata;
    logic          r1_ack;
    logic          r1_err;
    logic [2:0]    m_cmd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_resp;

    int   n_checks = 0;
    int   n_fail   = 0;
    txn_t sb[$];

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .RESET(RESET),
        .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_ack(r0_ack), .r0_err(r0_err),
        .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_ack(r1_ack), .r1_err(r1_err),
        .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic who, input logic [2:0] cmd, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic err);
        txn_t t;
        t.who   = who;
        t.cmd   = cmd;
        t.addr  = addr;
        t.wdata = wd;
        t.rdata = rd;
        t.err   = err;
        return t;
    endfunction

    // Returns at the negedge of the ISSUE cycle (or after the wait budget runs out).
    task automatic wait_issue(input txn_t e);
        bit seen = 0;
        int n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (m_cmd != 3'd0) seen = 1;
            else check("no_ack_before_issue", 32'({r0_ack, r1_ack}), 32'd0);
        end
        check("issue_seen", 32'(seen), 32'd1);
        check("m_cmd", 32'(m_cmd), 32'(e.cmd));
        check("m_addr", 32'(m_addr), 32'(e.addr));
        check("m_wdata", 32'(m_wdata), 32'(e.wdata));
    endtask

    task automatic check_ack(input txn_t e);
        check("r0_ack", 32'(r0_ack), 32'(!e.who));
        check("r1_ack", 32'(r1_ack), 32'(e.who));
        check("rdata", 32'(e.who ? r1_rdata : r0_rdata), 32'(e.rdata));
        check("err", 32'(e.who ? r1_err : r0_err), 32'(e.err));
    endtask

    // Cache model: answers dly cycles after ISSUE; returns at the negedge of the ack cycle.
    task automatic serve(input int dly);
        txn_t e;
        e = sb.pop_front();
        wait_issue(e);
        @(negedge clk);
        check("cmd_one_cycle", 32'(m_cmd), 32'd0);
        repeat (dly - 1) begin
            check("no_ack_in_wait", 32'({r0_ack, r1_ack}), 32'd0);
            @(negedge clk);
        end
        m_resp  = 1'b1;
        m_rdata = e.rdata;
        @(negedge clk);
        m_resp  = 1'b0;
        m_rdata = 16'hDEAD;
        check_ack(e);
    endtask

    initial begin
        txn_t e;
        RESET    = 1'b0;
        r0_cmd   = 3'd0; r0_addr = '0; r0_wdata = '0;
        r1_cmd   = 3'd0; r1_addr = '0; r1_wdata = '0;
        m_rdata  = 16'hDEAD;
        m_resp   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ctrl", 32'({m_cmd, r0_ack, r1_ack, r0_err, r1_err}), 32'd0);
        check("rst_maddr", 32'(m_addr), 32'd0);
        check("rst_mwdata", 32'(m_wdata), 32'd0);
        check("rst_rdata", {r0_rdata, r1_rdata}, 32'd0);

        // Contention straight out of reset: r0 first, then r1's write.
        RESET    = 1'b1;
        r0_cmd   = 3'd1; r0_addr = 15'h0100; r0_wdata = 16'h1111;
        r1_cmd   = 3'd5; r1_addr = 15'h0200; r1_wdata = 16'h00AA;
        sb.push_back(mk(1'b0, 3'd1, 15'h0100, 16'h1111, 16'h0011, 1'b0));
        sb.push_back(mk(1'b1, 3'd5, 15'h0200, 16'h00AA, 16'h5555, 1'b0));
        serve(2);
        r0_cmd = 3'd0;
        serve(1);

        // Round-robin with both requesters re-requesting immediately.
        r0_cmd = 3'd1; r0_addr = 15'h0AAA; r0_wdata = 16'h0A0A;
        r1_cmd = 3'd3; r1_addr = 15'h0555; r1_wdata = 16'h0505;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back(mk(1'b0, 3'd1, 15'h0AAA, 16'h0A0A, 16'(16'h1001 + i), 1'b0));
            else            sb.push_back(mk(1'b1, 3'd3, 15'h0555, 16'h0505, 16'(16'h1001 + i), 1'b0));
        end
        for (int i = 0; i < 4; i++) serve(1 + i);
        r0_cmd = 3'd0;
        r1_cmd = 3'd0;

        // Single READ16 with the response three cycles after ISSUE.
        r0_cmd = 3'd2; r0_addr = 15'h1234; r0_wdata = 16'h0000;
        sb.push_back(mk(1'b0, 3'd2, 15'h1234, 16'h0000, 16'hBEEF, 1'b0));
        serve(3);
        r0_cmd = 3'd0;

        // Illegal command 7 and stray responses in IDLE must do nothing.
        r1_cmd = 3'd7;
        for (int i = 0; i < 8; i++) begin
            m_resp = (i % 2 == 0);
            @(negedge clk);
            check("idle_quiet", 32'({m_cmd, r0_ack, r1_ack}), 32'd0);
        end
        m_resp = 1'b0;
        r1_cmd = 3'd0;
        check("rdata_hold", 32'(r0_rdata), 32'h0000BEEF);

        // Reset during WAIT abandons the transaction.
        r0_cmd = 3'd2; r0_addr = 15'h7FFF; r0_wdata = 16'h1234;
        e = mk(1'b0, 3'd2, 15'h7FFF, 16'h1234, 16'h0000, 1'b0);
        wait_issue(e);
        @(negedge clk);
        RESET = 1'b0;
        #1;
        check("rst_async_ctrl", 32'({m_cmd, r0_ack, r1_ack, r0_err, r1_err}), 32'd0);
        check("rst_async_maddr", 32'(m_addr), 32'd0);
        check("rst_async_mwdata", 32'(m_wdata), 32'd0);
        check("rst_async_rdata", {r0_rdata, r1_rdata}, 32'd0);
        r0_cmd = 3'd3; r0_addr = 15'h0010; r0_wdata = 16'h0000;
        r1_cmd = 3'd6; r1_addr = 15'h0042; r1_wdata = 16'hC0DE;
        sb.push_back(mk(1'b0, 3'd3, 15'h0010, 16'h0000, 16'h3333, 1'b0));
        sb.push_back(mk(1'b1, 3'd6, 15'h0042, 16'hC0DE, 16'h7777, 1'b0));
        @(negedge clk);
        RESET = 1'b1;
        serve(2);
        r0_cmd = 3'd0;
        serve(2);
        r1_cmd = 3'd0;

`ifdef ARB_TIMEOUT_EN
        begin
            int k;
            // No response: error ack TB_TO cycles after entering WAIT, with zero data.
            r0_cmd = 3'd2; r0_addr = 15'h0333; r0_wdata = 16'h0000;
            e = mk(1'b0, 3'd2, 15'h0333, 16'h0000, 16'h0000, 1'b1);
            wait_issue(e);
            k = 0;
            while (!(r0_ack || r1_ack) && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("timeout_latency", 32'(k), 32'(TB_TO + 1));
            check_ack(e);
            r0_cmd = 3'd0;

            // Response in the limit cycle wins over the watchdog.
            r0_cmd = 3'd1; r0_addr = 15'h0444; r0_wdata = 16'h0000;
            sb.push_back(mk(1'b0, 3'd1, 15'h0444, 16'h0000, 16'h4242, 1'b0));
            serve(TB_TO);
            r0_cmd = 3'd0;
        end
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single CPU-side cache port (cmd/addr/data, C1/A1/D1 domain) between two CPU requesters, r0 and r1.
- Sequences one transaction at a time: arbitrate, issue the command, wait for the cache response, return read data and an ack.
- Sits between the CPU cores and Cache.
- Uses unidirectional split buses; there is no tristate inside the block.

Parameters:
- ADDR_W, 15, address width (tag+set+offset).
- DATA_W, 16, data word width, matching the D1 bus.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- r0_cmd  in  3  r0 command: 0 NOP, 1-3 READ8/16/32, 4 INVALIDATE_LINE, 5-6 WRITE8/16; 7 is illegal from a requester.
- r0_addr  in  ADDR_W  r0 address.
- r0_wdata  in  DATA_W  r0 write data.
- r0_rdata  out  DATA_W  r0 read data, valid with r0_ack.
- r0_ack  out  1  one-cycle completion pulse to r0.
- r0_err  out  1  timeout flag, valid with r0_ack.
- r1_cmd, r1_addr, r1_wdata, r1_rdata, r1_ack, r1_err: same as r0_*, for r1.
- m_cmd  out  3  command to the cache.
- m_addr  out  ADDR_W  address to the cache.
- m_wdata  out  DATA_W  write data to the cache.
- m_rdata  in  DATA_W  read data from the cache.
- m_resp  in  1  cache response strobe (C1_RESPONSE, cmd 7).

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; all outputs 0 (m_cmd=NOP, acks 0, errs 0, rdata 0).
  - last_grant=1, so r0 wins the first contention.
- A requester is pending when its cmd is in 1..6. Values 0 and 7 mean no request.
- FSM states IDLE, ISSUE, WAIT, DONE:
  - IDLE: if any requester is pending, register grant and latch that requester's cmd/addr/wdata, then go to ISSUE.
    - Both pending: grant the one that is not last_grant.
    - One pending: grant it.
    - Update last_grant to the winner.
  - ISSUE: m_cmd = latched cmd for exactly 1 cycle; m_addr/m_wdata driven. Always go to WAIT.
  - WAIT: m_cmd=NOP; m_addr/m_wdata held stable. When m_resp=1, latch m_rdata into the granted rN_rdata and go to DONE.
  - DONE: rN_ack=1 for 1 cycle for the granted requester only; then go to IDLE.
- m_resp is sampled only in WAIT. It is ignored in IDLE, ISSUE and DONE.
- Latency:
  - pending in IDLE at cycle t -> m_cmd valid at t+1.
  - m_resp at cycle w -> ack at w+1.
  - minimum IDLE-to-IDLE turnaround is 4 cycles.
- rN_rdata holds its value until the next ack to that requester. For write and invalidate commands, rdata still latches m_rdata; its content is don't-care.
- Requester rules:
  - hold cmd/addr/wdata until its ack.
  - drive NOP in the cycle after ack, otherwise the arbiter sees a new request.
  - changing inputs while granted has no effect, because the fields are latched.
- The requester that is not granted may assert or drop its request freely; it is evaluated only in IDLE.
- Reset mid-transaction: return to IDLE immediately, no ack is issued, the in-flight transaction is abandoned. last_grant returns to 1.
- r0_ack and r1_ack are never high together.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With the macro:
  - an 8-bit-or-wider counter clears on entering WAIT and increments each WAIT cycle.
  - if it reaches TIMEOUT_CYC with no m_resp, go to DONE with rN_err=1 and rN_rdata=0.
  - m_resp arriving on the same cycle as the limit wins, giving a normal ack with err=0.
- Without the macro: WAIT lasts until m_resp, with no limit; r0_err and r1_err are tied to 0.

Test Plan:
- Single read: r0_cmd=2, addr=15'h1234; cache returns m_resp with m_rdata=16'hBEEF 3 cycles after ISSUE -> m_cmd=2 for exactly 1 cycle, r0_ack at resp+1, r0_rdata=16'hBEEF, r1_ack stays 0.
- Contention after reset: r0_cmd=1 and r1_cmd=5 (wdata=16'h00AA) in the same cycle -> r0 served first. After r0 drops to NOP, r1 is issued with m_cmd=5 and m_wdata=16'h00AA.
- Round-robin: both requesters re-request immediately for 4 transactions -> grant order r0, r1, r0, r1.
- Illegal and spurious inputs: r1_cmd=7 held, plus m_resp pulses in IDLE -> no m_cmd activity, no acks.
- Reset mid-WAIT: assert RESET during WAIT -> all outputs 0 asynchronously. After release, a pending r1 is issued with no stale ack.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=8: no m_resp -> r0_ack with r0_err=1 and r0_rdata=0, 8 cycles after entering WAIT. With m_resp exactly at count 8 -> err=0.
